ex1_sequencer: RTL
==================

# ex1_sequencer

Controller that sequences the 8-bit `out` datapath exercised by the ex1 bench. It accepts mode/data commands over a valid/ready handshake, loads a start value, then steps the output at a prescaled rate by counting up, counting down or rotating. It sits between a command source (bench or host FSM) and the 8-bit output register. It generates the update strobe used by downstream display or capture logic.

## Interface
- `DIV`, default 4: prescaler period in clock cycles between output steps while running. Legal range ≥1; `DIV`=1 steps every cycle.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_mode`  in  2  mode encoding:
  - 00 stop/hold
  - 01 count up
  - 10 count down
  - 11 rotate left
- `cmd_data`  in  8  start value; ignored for mode 00.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `out`  out  8  sequenced output value (registered).
- `step`  out  1  one-cycle pulse, high in the cycle in which `out` shows a newly stepped value.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- **State machine:** IDLE, LOAD, RUN.
- **Handshake:**
  - A command is accepted on a rising edge where `cmd_valid` and `cmd_ready` are both 1.
  - `cmd_ready` is 1 in IDLE and RUN and 0 in LOAD.
  - A command is accepted on a valid&ready edge only. There is no buffering; `cmd_valid` with `cmd_ready`=0 is ignored.
- **IDLE:** `out` holds its value, prescaler is idle, `step`=0. On accept: latch mode and data, go to LOAD.
- **LOAD (exactly one cycle):**
  - Mode ≠ 00: `out` ← latched data, prescaler ← 0, go to RUN.
  - Mode 00: `out` unchanged, go to IDLE.
- **RUN:**
  - Prescaler counts 0..DIV-1 and wraps.
  - On the edge where prescaler = DIV-1, `out` updates and `step` is registered high.
- **Update rules (8-bit modular arithmetic):**
  - Up: `out`+1, with 0xFF→0x00.
  - Down: `out`−1, with 0x00→0xFF.
  - Rotate: {`out`[6:0], `out`[7]}.
- **Command in RUN:** the command is accepted and pre-empts the run; go to LOAD. A command with mode 00 stops the sequence and freezes `out`.
- **Prescaler width:** max(1, clog2(DIV)) bits. The prescaler never exceeds DIV-1.

## Timing
- **Reset values** (on the first edge with `reset`=1): `out`=0x00, `step`=0, `busy`=0, `cmd_ready`=1, state IDLE, prescaler 0.
- **Reset priority:** reset overrides everything, including a simultaneous accept and a pending step.
- **Reset mid-RUN or mid-LOAD:** the block returns to the reset values at that edge. The latched command is discarded.
- **Latency:**
  - Accept at edge E0 → LOAD during cycle E0..E1.
  - `out` = start value after edge E1.
  - First step after edge E1+DIV, then every DIV edges.
- **`step`:** high for exactly one cycle per update. It is never high in IDLE or LOAD, or in the cycle after an accept.
- **Accept/step collision:** if an accept edge coincides with prescaler = DIV-1, the command wins. No update occurs and `step` stays 0 on that edge.
- **`busy`:** registered from state. It is 1 from the cycle after accept until the block returns to IDLE.
- **`cmd_ready`:** a registered function of state. It goes low the cycle after an accept and returns high one cycle later.

## Test plan
All scenarios use DIV=4.
- **Reset:** hold `reset` for 3 cycles with `cmd_valid`=1 → `out`=0x00, `step`=0, `busy`=0, `cmd_ready`=1; no command is accepted.
- **Count up with wrap:** mode 01, data 0xFE → `out`=0xFE at E1, 0xFF at E1+4, 0x00 at E1+8. `step` pulses exactly at those two updates; `cmd_ready`=0 only during LOAD.
- **Down and rotate:**
  - Mode 10, data 0x01 → 0x00 then 0xFF.
  - Mode 11, data 0x81 → 0x03, then 0x06, then 0x0C.
- **Collision and stop:**
  - In RUN, issue a mode 01 command (data 0x10) on the edge where prescaler = 3 → no step; `out`=0x10 at E1.
  - Then mode 00 → `out` frozen at its current value, `busy` drops after LOAD, `step` stays 0 for 20 cycles.
- **Handshake:** assert `cmd_valid` continuously with alternating commands → each accept is followed by one cycle of `cmd_ready`=0. The command presented during LOAD is ignored, not queued.
- **Reset mid-RUN:** assert `reset` for 1 cycle while `out`=0x37 → `out`=0x00 and state IDLE at that edge. There are no further steps until a new command.

Source files
------------

// File: rtl/ex1_sequencer_if.sv
// Command handshake and sequenced-output bundle for ex1_sequencer.
// The master modport belongs to the command source, and the slave modport belongs to the sequencer.
interface ex1_sequencer_if;
   logic       cmd_valid;
   logic [1:0] cmd_mode;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic [7:0] out;
   logic       step;
   logic       busy;

   modport master (
      output cmd_valid, cmd_mode, cmd_data,
      input  cmd_ready, out, step, busy
   );

   modport slave (
      input  cmd_valid, cmd_mode, cmd_data,
      output cmd_ready, out, step, busy
   );
endinterface

// File: rtl/ex1_sequencer.sv
// Prescaled output sequencer: loads a start value, then counts up, counts down or rotates left
// once every DIV cycles. A new command can be accepted in IDLE or RUN.
module ex1_sequencer #(
   parameter int unsigned DIV = 4
) (
   input  logic           clk,
   input  logic           reset,
   ex1_sequencer_if.slave bus
);

   localparam int unsigned PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_ROTL = 2'b11
   } mode_t;

   state_t        state_q, state_d;
   mode_t         mode_q, mode_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    out_q, out_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          step_q, step_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          accept_c;
   logic [7:0]    stepped_c;

   // Next output value for the latched mode.
   always_comb begin
      stepped_c = out_q;
      case (mode_q)
         MODE_UP:   stepped_c = out_q + 8'd1;
         MODE_DOWN: stepped_c = out_q - 8'd1;
         MODE_ROTL: stepped_c = {out_q[6:0], out_q[7]};
         default:   stepped_c = out_q;
      endcase
   end

   // Next-state and datapath control; an accept in RUN pre-empts a pending step.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      data_d   = data_q;
      out_d    = out_q;
      pre_d    = pre_q;
      step_d   = 1'b0;
      accept_c = bus.cmd_valid && ready_q;

      case (state_q)
         ST_IDLE: begin
            pre_d = '0;
            if (accept_c) begin
               mode_d  = mode_t'(bus.cmd_mode);
               data_d  = bus.cmd_data;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            pre_d = '0;
            if (mode_q != MODE_HOLD) begin
               out_d   = data_q;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept_c) begin
               mode_d  = mode_t'(bus.cmd_mode);
               data_d  = bus.cmd_data;
               state_d = ST_LOAD;
            end else if (pre_q == PRE_LAST) begin
               pre_d  = '0;
               out_d  = stepped_c;
               step_d = 1'b1;
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            pre_d   = '0;
         end
      endcase

      ready_d = (state_d != ST_LOAD);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_HOLD;
         data_q  <= 8'h00;
         out_q   <= 8'h00;
         pre_q   <= '0;
         step_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
         out_q   <= out_d;
         pre_q   <= pre_d;
         step_q  <= step_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.step      = step_q;
   assign bus.cmd_ready = ready_q;
   assign bus.busy      = busy_q;

endmodule
